// File: rtl/alu_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_if
// Brief    : Requester, response and ALU-side signals of the two-port ALU arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arb_if;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [15:0] req_a_i;
    logic [15:0] req_b_i;
    logic [5:0]  req_inst_i;
    logic [1:0]  rsp_valid_o;
    logic [1:0]  rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [7:0]  alu_data_a_o;
    logic [7:0]  alu_data_b_o;
    logic [2:0]  alu_inst_o;
    logic [15:0] alu_data_i;
    logic        busy_o;

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_inst_i, rsp_ready_i, alu_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, alu_data_a_o, alu_data_b_o,
               alu_inst_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_inst_i, rsp_ready_i, alu_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, alu_data_a_o, alu_data_b_o,
               alu_inst_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb
// Brief    : Round-robin sharing of one fixed-latency ALU between two requesters
// Revision : 1.0 - initial release
// ============================================================================
module alu_arb #(
    parameter int LATENCY = 1
) (
    input  wire logic  clk_p_i,
    input  wire logic  reset_n_i,
    alu_arb_if.slave   bus
);
    logic [LATENCY:0] r_stg_vld;
    logic [LATENCY:0] r_stg_id;
    logic             r_last;
    logic [7:0]       r_alu_a;
    logic [7:0]       r_alu_b;
    logic [2:0]       r_alu_inst;

    logic [1:0]       w_inflight;
    logic [1:0]       w_elig;
    logic [1:0]       w_grant;
    logic [1:0]       w_rsp_vld;
    logic             w_accept;
    logic             w_win;

    // A port stays in flight until its result lands in the response register,
    // which is what keeps that one-entry register from ever overflowing.
    always_comb begin
        w_inflight = 2'b00;
        for (int s = 0; s <= LATENCY; s++) begin
            if (r_stg_vld[s]) begin
                w_inflight[r_stg_id[s]] = 1'b1;
            end
        end
    end

    assign w_elig = bus.req_valid_i & ~w_inflight & (~w_rsp_vld | bus.rsp_ready_i);

    always_comb begin
        w_grant = 2'b00;
        case (w_elig)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
        if (!reset_n_i) begin
            w_grant = 2'b00;
        end
    end

    assign w_accept = |w_grant;
    assign w_win    = w_grant[1];

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_stg_vld  <= '0;
            r_stg_id   <= '0;
            r_last     <= 1'b1;
            r_alu_a    <= 8'h00;
            r_alu_b    <= 8'h00;
            r_alu_inst <= 3'b000;
        end else begin
            r_stg_vld <= {r_stg_vld[LATENCY-1:0], w_accept};
            r_stg_id  <= {r_stg_id[LATENCY-1:0], w_win};
            if (w_accept) begin
                r_last     <= w_win;
                r_alu_a    <= w_win ? bus.req_a_i[15:8]   : bus.req_a_i[7:0];
                r_alu_b    <= w_win ? bus.req_b_i[15:8]   : bus.req_b_i[7:0];
                r_alu_inst <= w_win ? bus.req_inst_i[5:3] : bus.req_inst_i[2:0];
            end
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_port
        logic        r_vld;
        logic [15:0] r_data;
        logic        w_capture;

        assign w_capture = r_stg_vld[LATENCY] && (r_stg_id[LATENCY] == 1'(k));

        always_ff @(posedge clk_p_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_vld  <= 1'b0;
                r_data <= 16'h0000;
            end else if (w_capture) begin
                r_vld  <= 1'b1;
                r_data <= bus.alu_data_i;
            end else if (r_vld && bus.rsp_ready_i[k]) begin
                r_vld  <= 1'b0;
            end
        end

        assign w_rsp_vld[k]               = r_vld;
        assign bus.rsp_data_o[16*k +: 16] = r_data;
    end

    assign bus.rsp_valid_o  = w_rsp_vld;
    assign bus.req_ready_o  = w_grant;
    assign bus.alu_data_a_o = r_alu_a;
    assign bus.alu_data_b_o = r_alu_b;
    assign bus.alu_inst_o   = r_alu_inst;
    assign bus.busy_o       = (|r_stg_vld) | (|w_rsp_vld);
endmodule
`default_nettype wire

// File: tb/tb_alu_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arb
// Brief    : Randomized and directed bench for alu_arb against a transaction model
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arb;
    localparam int c_LAT = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arb_if bus ();
    alu_arb_if bus3 ();

    alu_arb #(.LATENCY(c_LAT)) dut  (.clk_p_i(clk), .reset_n_i(rst_n), .bus(bus.slave));
    alu_arb #(.LATENCY(3))     dut3 (.clk_p_i(clk), .reset_n_i(rst_n), .bus(bus3.slave));

    // Stub ALUs: result is {a, b}, delayed by the instance's latency.
    logic [15:0] alu1_q;
    logic [15:0] alu3_q [3];
    always @(posedge clk) begin
        alu1_q    <= {bus.alu_data_a_o, bus.alu_data_b_o};
        alu3_q[0] <= {bus3.alu_data_a_o, bus3.alu_data_b_o};
        alu3_q[1] <= alu3_q[0];
        alu3_q[2] <= alu3_q[1];
    end
    assign bus.alu_data_i  = alu1_q;
    assign bus3.alu_data_i = alu3_q[2];

    int n_chk;
    int n_fail;

    // Transaction-level model: outstanding op per port with the edge it completes on.
    bit          m_op [2];
    int          m_done [2];
    logic [15:0] m_pend [2];
    bit          m_rv [2];
    logic [15:0] m_rd [2];
    logic [7:0]  m_a, m_b;
    logic [2:0]  m_i;
    int          m_last;
    int          edge_n;

    int          s_grant;
    logic [7:0]  s_a, s_b;
    logic [2:0]  s_i;
    bit          s_pop [2];
    logic [1:0]  obs_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_op[k] = 0; m_done[k] = 0; m_pend[k] = 16'h0; m_rv[k] = 0; m_rd[k] = 16'h0;
        end
        m_a = 8'h0; m_b = 8'h0; m_i = 3'h0; m_last = 1; s_grant = -1;
    endtask

    task automatic model_eval();
        bit         elig [2];
        logic [1:0] exp_ready;
        for (int k = 0; k < 2; k++) begin
            elig[k]  = bus.req_valid_i[k] && !m_op[k] && (!m_rv[k] || bus.rsp_ready_i[k]);
            s_pop[k] = m_rv[k] && bus.rsp_ready_i[k];
        end
        if (elig[0] && elig[1]) s_grant = (m_last == 1) ? 0 : 1;
        else if (elig[0])       s_grant = 0;
        else if (elig[1])       s_grant = 1;
        else                    s_grant = -1;
        exp_ready = (s_grant == 0) ? 2'b01 : (s_grant == 1) ? 2'b10 : 2'b00;
        if (s_grant >= 0) begin
            s_a = bus.req_a_i[8*s_grant +: 8];
            s_b = bus.req_b_i[8*s_grant +: 8];
            s_i = bus.req_inst_i[3*s_grant +: 3];
        end
        obs_ready = bus.req_ready_o;
        chk("req_ready", 32'(obs_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(bus.rsp_valid_o), 32'({m_rv[1], m_rv[0]}));
        chk("rsp_data", bus.rsp_data_o, {m_rd[1], m_rd[0]});
        chk("busy", 32'(bus.busy_o), 32'(m_op[0] | m_op[1] | m_rv[0] | m_rv[1]));
        chk("alu_a", 32'(bus.alu_data_a_o), 32'(m_a));
        chk("alu_b", 32'(bus.alu_data_b_o), 32'(m_b));
        chk("alu_inst", 32'(bus.alu_inst_o), 32'(m_i));
    endtask

    task automatic model_update();
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            if (s_pop[k]) m_rv[k] = 0;
            if (m_op[k] && m_done[k] == edge_n) begin
                m_rv[k] = 1; m_rd[k] = m_pend[k]; m_op[k] = 0;
            end
        end
        if (s_grant >= 0) begin
            m_op[s_grant]   = 1;
            m_done[s_grant] = edge_n + c_LAT + 1;
            m_pend[s_grant] = {s_a, s_b};
            m_a = s_a; m_b = s_b; m_i = s_i;
            m_last = s_grant;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] i);
        bus.req_valid_i[k]        = 1'b1;
        bus.req_a_i[8*k +: 8]     = a;
        bus.req_b_i[8*k +: 8]     = b;
        bus.req_inst_i[3*k +: 3]  = i;
    endtask

    task automatic rand_drive();
        for (int k = 0; k < 2; k++) begin
            if (!bus.req_valid_i[k] || s_grant == k) begin
                if ($urandom_range(0, 9) < 6) set_req(k, 8'($urandom), 8'($urandom), 3'($urandom));
                else bus.req_valid_i[k] = 1'b0;
            end
            bus.rsp_ready_i[k] = ($urandom_range(0, 9) < 7);
        end
    endtask

    task automatic drain();
        bus.req_valid_i = 2'b00;
        bus.rsp_ready_i = 2'b11;
        for (int i = 0; i < 20 && bus.busy_o; i++) cycle();
        chk("drain_idle", 32'(bus.busy_o), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0acc;
        int lat;
        n_chk = 0; n_fail = 0; edge_n = 0;
        model_reset();
        bus.req_valid_i = 2'b11; bus.req_a_i = '0; bus.req_b_i = '0; bus.req_inst_i = '0;
        bus.rsp_ready_i = 2'b00;
        bus3.req_valid_i = 2'b00; bus3.req_a_i = '0; bus3.req_b_i = '0; bus3.req_inst_i = '0;
        bus3.rsp_ready_i = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(bus.req_ready_o), 32'(0));
        chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'(0));
        chk("reset_rsp_data", bus.rsp_data_o, 32'(0));
        chk("reset_busy", 32'(bus.busy_o), 32'(0));
        chk("reset_alu_a", 32'(bus.alu_data_a_o), 32'(0));
        bus.req_valid_i = 2'b00;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Tie straight out of reset: port 0 first, then port 1.
        set_req(0, 8'd37, 8'd128, 3'd1); set_req(1, 8'd50, 8'd60, 3'd2);
        bus.rsp_ready_i = 2'b11;
        cycle(); chk("tie1_first", 32'(obs_ready), 32'(2'b01)); bus.req_valid_i[0] = 1'b0;
        cycle(); chk("tie1_second", 32'(obs_ready), 32'(2'b10)); bus.req_valid_i[1] = 1'b0;
        cycle();
        chk("tie_p0_valid", 32'(bus.rsp_valid_o), 32'(2'b01));
        chk("tie_p0_data", 32'(bus.rsp_data_o[15:0]), 32'(16'h2580));
        cycle();
        chk("tie_p1_valid", 32'(bus.rsp_valid_o), 32'(2'b10));
        chk("tie_p1_data", 32'(bus.rsp_data_o[31:16]), 32'(16'h323C));
        drain();
        set_req(0, 8'd5, 8'd6, 3'd0); set_req(1, 8'd7, 8'd8, 3'd0);
        cycle(); chk("tie2_first", 32'(obs_ready), 32'(2'b01)); bus.req_valid_i[0] = 1'b0;
        cycle(); bus.req_valid_i[1] = 1'b0;
        drain();

        // Single request on port 0.
        set_req(0, 8'd25, 8'd35, 3'b011); bus.rsp_ready_i = 2'b00;
        cycle(); chk("single_grant", 32'(obs_ready), 32'(2'b01)); bus.req_valid_i[0] = 1'b0;
        cycle();
        cycle();
        chk("single_valid", 32'(bus.rsp_valid_o[0]), 32'(1));
        chk("single_data", 32'(bus.rsp_data_o[15:0]), 32'(16'h1923));
        bus.rsp_ready_i = 2'b01;
        cycle(); chk("single_busy_after_pop", 32'(bus.busy_o), 32'(0));

        // Back-pressure on port 1 while port 0 keeps issuing.
        set_req(1, 8'd1, 8'd2, 3'd0); bus.rsp_ready_i = 2'b00;
        cycle(); bus.req_valid_i[1] = 1'b0;
        cycle(); cycle();
        set_req(1, 8'd65, 8'd100, 3'd4); bus.rsp_ready_i = 2'b01;
        set_req(0, 8'($urandom), 8'($urandom), 3'($urandom));
        p0acc = 0;
        repeat (6) begin
            cycle();
            chk("bp_hold_p1", 32'(obs_ready[1]), 32'(0));
            if (s_grant == 0) begin
                p0acc++;
                set_req(0, 8'($urandom), 8'($urandom), 3'($urandom));
            end
        end
        chk("bp_p0_issued", 32'(p0acc != 0), 32'(1));
        bus.rsp_ready_i = 2'b11;
        cycle(); chk("bp_release", 32'(obs_ready[1]), 32'(1));
        bus.req_valid_i = 2'b00; bus.rsp_ready_i = 2'b01;
        cycle(); cycle();
        chk("bp_p1_valid", 32'(bus.rsp_valid_o[1]), 32'(1));
        chk("bp_p1_data", 32'(bus.rsp_data_o[31:16]), 32'(16'h4164));
        drain();

        // Single-port cadence with immediate pops.
        set_req(0, 8'($urandom), 8'($urandom), 3'($urandom)); bus.rsp_ready_i = 2'b11;
        repeat (12) begin
            cycle();
            if (s_grant == 0) set_req(0, 8'($urandom), 8'($urandom), 3'($urandom));
        end
        drain();

        // Reset pulse one cycle after an accept.
        set_req(0, 8'd9, 8'd10, 3'd5);
        cycle(); chk("rst_pre_grant", 32'(obs_ready), 32'(2'b01)); bus.req_valid_i[0] = 1'b0;
        cycle();
        rst_n = 1'b0; bus.req_valid_i = 2'b11;
        #2;
        chk("rst_ready", 32'(bus.req_ready_o), 32'(0));
        chk("rst_busy", 32'(bus.busy_o), 32'(0));
        chk("rst_alu_a", 32'(bus.alu_data_a_o), 32'(0));
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'(0));
        model_reset();
        bus.req_valid_i = 2'b00;
        @(negedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (4) cycle();
        set_req(0, 8'd11, 8'd12, 3'd1); set_req(1, 8'd13, 8'd14, 3'd2);
        cycle(); chk("rst_tie_grant", 32'(obs_ready), 32'(2'b01)); bus.req_valid_i[0] = 1'b0;
        cycle(); bus.req_valid_i[1] = 1'b0;
        drain();

        // Randomized traffic.
        repeat (400) begin
            cycle();
            rand_drive();
        end
        drain();

        // Deeper ALU pipeline: single request on the LATENCY=3 instance.
        bus3.req_valid_i = 2'b01; bus3.req_a_i[7:0] = 8'd25; bus3.req_b_i[7:0] = 8'd35;
        bus3.req_inst_i[2:0] = 3'b011; bus3.rsp_ready_i = 2'b00;
        @(negedge clk);
        chk("l3_grant", 32'(bus3.req_ready_o), 32'(2'b01));
        @(posedge clk); #1;
        bus3.req_valid_i = 2'b00;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (bus3.rsp_valid_o[0]) begin
                lat = i;
                break;
            end
        end
        chk("l3_latency", 32'(lat), 32'(4));
        chk("l3_data", 32'(bus3.rsp_data_o[15:0]), 32'(16'h1923));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
